// File: rtl/neo_crom_pkg.sv
// Shared types and constants for the sprite C-ROM fetch path.
// Holds the fetch FSM encoding, address widths and the saturating counter helper.
package neo_crom_pkg;

  localparam int unsigned C_ADDR_W       = 24;
  localparam int unsigned SDR_ADDR_W     = 27;
  localparam int unsigned SDR_ADDR_SHIFT = 3;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StBeat0,
    StBeat1
  } fetch_state_e;

  // Increment that sticks at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/neo_crom_linebuf.sv
// Double-buffered tile line: back buffer filled by SDRAM beats, front buffer
// swapped in on ZMC2 LOAD and muxed onto CR by CA4.
module neo_crom_linebuf
  import neo_crom_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             beat0_we_i,
  input  logic             beat1_we_i,
  input  logic [31:0]      data_i,
  input  logic             load_i,
  input  logic             ca4_i,
  output logic [31:0]      cr_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  logic [31:0]      back_lo_q, back_lo_d;
  logic [31:0]      back_hi_q, back_hi_d;
  logic             back_v_q, back_v_d;
  logic [63:0]      front_q, front_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    back_lo_d  = back_lo_q;
    back_hi_d  = back_hi_q;
    back_v_d   = back_v_q;
    front_d    = front_q;
    miss_cnt_d = miss_cnt_q;
    if (beat0_we_i) back_lo_d = data_i;
    if (beat1_we_i) begin
      back_hi_d = data_i;
      back_v_d  = 1'b1;
    end
    if (load_i) begin
      back_v_d = 1'b0;
      // A line completing in the LOAD cycle bypasses the back buffer.
      if (beat1_we_i) begin
        front_d = {data_i, back_lo_q};
      end else if (back_v_q) begin
        front_d = {back_hi_q, back_lo_q};
      end else begin
        front_d    = '0;
        miss_cnt_d = CNT_W'(sat_inc(32'(miss_cnt_q), CNT_W));
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      back_lo_q  <= '0;
      back_hi_q  <= '0;
      back_v_q   <= 1'b0;
      front_q    <= '0;
      miss_cnt_q <= '0;
    end else begin
      back_lo_q  <= back_lo_d;
      back_hi_q  <= back_hi_d;
      back_v_q   <= back_v_d;
      front_q    <= front_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign cr_o       = ca4_i ? front_q[31:0] : front_q[63:32];
  assign miss_cnt_o = miss_cnt_q;

endmodule

// File: rtl/neo_crom_fetch.sv
// Sprite C-ROM fetch controller: captures the tile-line address on PCK1 and
// bursts two 32-bit words from SDRAM into the line buffer for ZMC2.
module neo_crom_fetch
  import neo_crom_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic                  CLK,
  input  logic                  nRESET,
  input  logic                  PCK1_EN_N,
  input  logic [C_ADDR_W-1:0]   C_ADDR,
  input  logic                  LOAD_EN,
  input  logic                  CA4,
  output logic [31:0]           CR,
  output logic                  SDR_REQ,
  output logic [SDR_ADDR_W-1:0] SDR_ADDR,
  input  logic                  SDR_ACK,
  input  logic                  SDR_VALID,
  input  logic [31:0]           SDR_DATA,
  output logic [CNT_W-1:0]      MISS_CNT,
  output logic [CNT_W-1:0]      OVR_CNT
);

  fetch_state_e        state_q, state_d;
  logic [C_ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [C_ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic                pend_v_q, pend_v_d;
  logic                pck1_q;
  logic [CNT_W-1:0]    ovr_cnt_q, ovr_cnt_d;
  logic                ovr_inc;
  logic                beat0_we;
  logic                beat1_we;

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    pend_addr_d = pend_addr_q;
    pend_v_d    = pend_v_q;
    ovr_inc     = 1'b0;
    beat0_we    = 1'b0;
    beat1_we    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A fresh capture supersedes any address still waiting in pending.
        if (pck1_q) begin
          cur_addr_d = C_ADDR;
          pend_v_d   = 1'b0;
          ovr_inc    = pend_v_q;
          state_d    = StReq;
        end else if (pend_v_q) begin
          cur_addr_d = pend_addr_q;
          pend_v_d   = 1'b0;
          state_d    = StReq;
        end
      end
      StReq: begin
        if (SDR_ACK) state_d = StBeat0;
      end
      StBeat0: begin
        if (SDR_VALID) begin
          beat0_we = 1'b1;
          state_d  = StBeat1;
        end
      end
      StBeat1: begin
        if (SDR_VALID) begin
          beat1_we = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (pck1_q && (state_q != StIdle)) begin
      pend_addr_d = C_ADDR;
      pend_v_d    = 1'b1;
      ovr_inc     = pend_v_q;
    end

    ovr_cnt_d = ovr_inc ? CNT_W'(sat_inc(32'(ovr_cnt_q), CNT_W)) : ovr_cnt_q;
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      pend_addr_q <= '0;
      pend_v_q    <= 1'b0;
      pck1_q      <= 1'b0;
      ovr_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      pend_addr_q <= pend_addr_d;
      pend_v_q    <= pend_v_d;
      pck1_q      <= ~PCK1_EN_N;
      ovr_cnt_q   <= ovr_cnt_d;
    end
  end

  assign SDR_REQ  = (state_q == StReq);
  assign SDR_ADDR = {cur_addr_q, {SDR_ADDR_SHIFT{1'b0}}};
  assign OVR_CNT  = ovr_cnt_q;

  neo_crom_linebuf #(
    .CNT_W (CNT_W)
  ) u_linebuf (
    .clk_i      (CLK),
    .rst_ni     (nRESET),
    .beat0_we_i (beat0_we),
    .beat1_we_i (beat1_we),
    .data_i     (SDR_DATA),
    .load_i     (LOAD_EN),
    .ca4_i      (CA4),
    .cr_o       (CR),
    .miss_cnt_o (MISS_CNT)
  );

endmodule

// File: tb/tb_neo_crom_fetch.sv
// Self-checking bench for neo_crom_fetch: expected SDRAM addresses and front
// buffer contents are queued at stimulus time and compared when the DUT produces them.
module tb_neo_crom_fetch;

  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             n_reset;
  logic             pck1_en_n;
  logic [23:0]      c_addr;
  logic             load_en;
  logic             ca4;
  logic [31:0]      cr;
  logic             sdr_req;
  logic [26:0]      sdr_addr;
  logic             sdr_ack;
  logic             sdr_valid;
  logic [31:0]      sdr_data;
  logic [CNT_W-1:0] miss_cnt;
  logic [CNT_W-1:0] ovr_cnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned exp_miss = 0;
  int unsigned exp_ovr  = 0;

  logic [26:0] addr_q[$];
  logic [63:0] front_q[$];

  neo_crom_fetch #(
    .CNT_W (CNT_W)
  ) dut (
    .CLK       (clk),
    .nRESET    (n_reset),
    .PCK1_EN_N (pck1_en_n),
    .C_ADDR    (c_addr),
    .LOAD_EN   (load_en),
    .CA4       (ca4),
    .CR        (cr),
    .SDR_REQ   (sdr_req),
    .SDR_ADDR  (sdr_addr),
    .SDR_ACK   (sdr_ack),
    .SDR_VALID (sdr_valid),
    .SDR_DATA  (sdr_data),
    .MISS_CNT  (miss_cnt),
    .OVR_CNT   (ovr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pck1(input logic [23:0] addr);
    pck1_en_n = 1'b0;
    tick();
    pck1_en_n = 1'b1;
    c_addr    = addr;
    tick();
  endtask

  task automatic wait_req();
    logic [26:0] exp_addr;
    int          waited;
    waited = 0;
    while (!sdr_req && waited < 60) begin
      tick();
      waited++;
    end
    check_eq("req_timeout", 64'(sdr_req), 64'd1);
    if (addr_q.size() == 0) begin
      check_eq("addr_q_empty", 64'(addr_q.size()), 64'd1);
    end else begin
      exp_addr = addr_q.pop_front();
      check_eq("sdr_addr", 64'(sdr_addr), 64'(exp_addr));
    end
  endtask

  task automatic ack(input int delay);
    repeat (delay) tick();
    check_eq("req_hold", 64'(sdr_req), 64'd1);
    sdr_ack = 1'b1;
    tick();
    sdr_ack = 1'b0;
    check_eq("req_drop", 64'(sdr_req), 64'd0);
  endtask

  task automatic beat(input logic [31:0] d, input int gap, input logic with_load);
    repeat (gap) tick();
    sdr_valid = 1'b1;
    sdr_data  = d;
    load_en   = with_load;
    tick();
    sdr_valid = 1'b0;
    load_en   = 1'b0;
  endtask

  task automatic check_front();
    logic [63:0] exp;
    if (front_q.size() == 0) begin
      check_eq("front_q_empty", 64'(front_q.size()), 64'd1);
    end else begin
      exp = front_q.pop_front();
      ca4 = 1'b1;
      #1;
      check_eq("cr_ca4_1", 64'(cr), 64'(exp[31:0]));
      ca4 = 1'b0;
      #1;
      check_eq("cr_ca4_0", 64'(cr), 64'(exp[63:32]));
    end
  endtask

  task automatic load_check();
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
    check_front();
  endtask

  task automatic check_cnts();
    check_eq("miss_cnt", 64'(miss_cnt), 64'(exp_miss));
    check_eq("ovr_cnt", 64'(ovr_cnt), 64'(exp_ovr));
  endtask

  initial begin
    int req_seen;
    n_reset   = 1'b0;
    pck1_en_n = 1'b1;
    c_addr    = '0;
    load_en   = 1'b0;
    ca4       = 1'b0;
    sdr_ack   = 1'b0;
    sdr_valid = 1'b0;
    sdr_data  = '0;

    // Reset held with random activity on every input.
    for (int i = 0; i < 8; i++) begin
      pck1_en_n = 1'($urandom);
      c_addr    = 24'($urandom);
      load_en   = 1'($urandom);
      ca4       = 1'($urandom);
      sdr_ack   = 1'($urandom);
      sdr_valid = 1'($urandom);
      sdr_data  = $urandom;
      tick();
    end
    check_eq("rst_cr", 64'(cr), 64'd0);
    check_eq("rst_req", 64'(sdr_req), 64'd0);
    check_eq("rst_addr", 64'(sdr_addr), 64'd0);
    check_cnts();
    pck1_en_n = 1'b1;
    load_en   = 1'b0;
    sdr_ack   = 1'b0;
    sdr_valid = 1'b0;
    n_reset   = 1'b1;
    repeat (4) tick();
    check_eq("idle_req", 64'(sdr_req), 64'd0);

    // Basic fetch.
    addr_q.push_back(27'h091A2B0);
    pck1(24'h123456);
    check_eq("req_latency", 64'(sdr_req), 64'd1);
    wait_req();
    ack(3);
    beat(32'hAAAA0001, 0, 1'b0);
    beat(32'hBBBB0002, 1, 1'b0);
    front_q.push_back({32'hBBBB0002, 32'hAAAA0001});
    tick();
    load_check();
    check_cnts();

    // LOAD while BEAT0 is outstanding: transparent line, later swap at next LOAD.
    addr_q.push_back({24'h000ABC, 3'b000});
    pck1(24'h000ABC);
    wait_req();
    ack(1);
    front_q.push_back(64'h0);
    load_check();
    exp_miss++;
    check_cnts();
    beat(32'h11111111, 2, 1'b0);
    beat(32'h22222222, 0, 1'b0);
    front_q.push_back({32'h22222222, 32'h11111111});
    tick();
    load_check();
    check_cnts();

    // LOAD coincident with the last beat goes straight to the front buffer.
    addr_q.push_back({24'hFEDCBA, 3'b000});
    pck1(24'hFEDCBA);
    wait_req();
    ack(0);
    beat(32'h33333333, 0, 1'b0);
    front_q.push_back({32'h44444444, 32'h33333333});
    beat(32'h44444444, 1, 1'b1);
    check_front();
    check_cnts();
    front_q.push_back(64'h0);
    load_check();
    exp_miss++;
    check_cnts();

    // Three PCK1s within one burst: B is overwritten by C.
    addr_q.push_back({24'h0A0A0A, 3'b000});
    pck1(24'h0A0A0A);
    wait_req();
    ack(0);
    pck1(24'h0B0B0B);
    pck1(24'h0C0C0C);
    exp_ovr++;
    check_cnts();
    beat(32'h55555555, 0, 1'b0);
    beat(32'h66666666, 0, 1'b0);
    addr_q.push_back({24'h0C0C0C, 3'b000});
    wait_req();
    ack(2);
    beat(32'h77777777, 1, 1'b0);
    beat(32'h88888888, 0, 1'b0);
    front_q.push_back({32'h88888888, 32'h77777777});
    tick();
    load_check();
    req_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (sdr_req) req_seen++;
      tick();
    end
    check_eq("no_extra_req", 64'(req_seen), 64'd0);
    check_cnts();

    // Reset in the middle of a burst; stray beats afterwards must not fill back.
    addr_q.push_back({24'h5A5A5A, 3'b000});
    pck1(24'h5A5A5A);
    wait_req();
    ack(0);
    n_reset = 1'b0;
    #1;
    exp_miss = 0;
    exp_ovr  = 0;
    check_eq("mid_rst_req", 64'(sdr_req), 64'd0);
    ca4 = 1'b1;
    #1;
    check_eq("mid_rst_cr", 64'(cr), 64'd0);
    check_cnts();
    tick();
    n_reset = 1'b1;
    beat(32'h99999999, 0, 1'b0);
    beat(32'hAAAAAAAA, 0, 1'b0);
    check_eq("post_rst_req", 64'(sdr_req), 64'd0);
    front_q.push_back(64'h0);
    load_check();
    exp_miss++;
    check_cnts();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
